interrupt_ctrl: RTL and testbench

//  Central interrupt controller/arbiter for the VerilogBoy CPU. Collects req/ack-style

---
 rtl/interrupt_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_interrupt_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
//   Central interrupt controller / arbiter for the VerilogBoy CPU.
//   Peripherals (VBlank, LCD STAT, timer, serial, joypad) raise level requests
//   that stay high until acknowledged. A rising request edge sets the matching
//   IF bit. IF (FF0F) and IE (FFFF) are CPU-visible. The highest-priority
//   enabled pending source (lowest index) is offered to the CPU with its
//   vector. On CPU dispatch the winning IF bit is cleared and the source gets a
//   one-cycle ack pulse.
//
//   Optional build macro: INTC_VECTOR_LATCH_EN
//     defined   : the offered source is chosen when the request is raised and
//                 stays fixed until dispatched or withdrawn (no preemption).
//     undefined : the offered source tracks the current winner every cycle,
//                 so a higher-priority arrival preempts the offer.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   a, din, wr      CPU bus address, write data, write strobe
//   rd              CPU read strobe (dout decodes a only)
//   dout            CPU read data, combinational from a
//   int_req         peripheral requests, held high until acked
//   int_ack         one-cycle ack pulses to peripherals
//   cpu_int_req     registered "enabled interrupt pending" to the CPU
//   cpu_int_vector  vector of the interrupt being offered
//   cpu_int_ack     CPU dispatch pulse, honoured only while offering
// -----------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter int          NUM_SRC    = 5,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter int          VEC_STRIDE = 8,
  parameter logic [15:0] IF_ADDR    = 16'hff0f,
  parameter logic [15:0] IE_ADDR    = 16'hffff
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_SRC-1:0] int_req,
  output logic [NUM_SRC-1:0] int_ack,
  output logic               cpu_int_req,
  output logic [7:0]         cpu_int_vector,
  input  logic               cpu_int_ack
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] if_reg, if_next;
  logic [7:0]         ie_reg, ie_next;
  logic [NUM_SRC-1:0] req_d_reg;
  logic [NUM_SRC-1:0] int_ack_reg, int_ack_next;
  logic               cpu_int_req_reg, cpu_int_req_next;
  // Index of the source currently offered to the CPU; the vector is derived
  // from it, and it is also the index dispatched on cpu_int_ack.
  logic [IDX_W-1:0]   idx_reg, idx_next;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend, pend_next;
  logic [NUM_SRC-1:0] disp_mask;
  logic [NUM_SRC-1:0] sw_clr;
  logic               wr_if, wr_ie;
  logic [7:0]         if_read;
  logic               unused_rd;

  // Lowest set bit wins (bit 0 = highest priority).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_BASE + 8'(VEC_STRIDE) * 8'(idx);
  endfunction

  assign unused_rd = rd;

  assign wr_if = wr && (a == IF_ADDR);
  assign wr_ie = wr && (a == IE_ADDR);
  assign rise  = int_req & ~req_d_reg;
  assign pend  = if_reg & ie_reg[NUM_SRC-1:0];
  assign ie_next = wr_ie ? din : ie_reg;

  // ---------------------------------------------------------------------------
  // Offer / dispatch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    cpu_int_req_next = cpu_int_req_reg;
    disp_mask        = '0;
    case (state_reg)
      IDLE: begin
        if (pend != '0) begin
          state_next       = REQ;
          cpu_int_req_next = 1'b1;
        end
      end
      REQ: begin
        // Offer withdrawn (IF or IE cleared by software): no ack is issued.
        if (!pend[idx_reg]) begin
          state_next       = IDLE;
          cpu_int_req_next = 1'b0;
        end else if (cpu_int_ack) begin
          disp_mask        = NUM_SRC'(1) << idx_reg;
          state_next       = ACK;
          cpu_int_req_next = 1'b0;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next       = IDLE;
        cpu_int_req_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // IF bit update: capture set beats dispatch clear beats CPU write
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_if_bit
      assign if_next[gi] = rise[gi]      ? 1'b1 :
                           disp_mask[gi] ? 1'b0 :
                           wr_if         ? din[gi] :
                                           if_reg[gi];
    end
  endgenerate

  // Software clear of a still-requesting source must ack it, otherwise the
  // peripheral would hold its level forever and never produce a new edge.
  assign sw_clr       = wr_if ? (if_reg & ~if_next & int_req) : '0;
  assign int_ack_next = disp_mask | sw_clr;

  assign pend_next = if_next & ie_next[NUM_SRC-1:0];

  // Offered index follows the pending set as it will look next cycle, so the
  // vector register lines up with cpu_int_req and with the dispatched index.
  always_comb begin
    idx_next = idx_reg;
`ifdef INTC_VECTOR_LATCH_EN
    if ((state_reg == IDLE) && (state_next == REQ)) begin
      idx_next = lowest_set(pend_next);
    end
`else
    if ((state_next == REQ) && (pend_next != '0)) begin
      idx_next = lowest_set(pend_next);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      if_reg          <= '0;
      ie_reg          <= 8'h00;
      req_d_reg       <= '0;
      int_ack_reg     <= '0;
      cpu_int_req_reg <= 1'b0;
      idx_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      if_reg          <= if_next;
      ie_reg          <= ie_next;
      req_d_reg       <= int_req;
      int_ack_reg     <= int_ack_next;
      cpu_int_req_reg <= cpu_int_req_next;
      idx_reg         <= idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Unimplemented IF bits read back as 1.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_if_read
      if (gi < NUM_SRC) begin : g_impl
        assign if_read[gi] = if_reg[gi];
      end else begin : g_pad
        assign if_read[gi] = 1'b1;
      end
    end
  endgenerate

  assign dout = (a == IF_ADDR) ? if_read :
                (a == IE_ADDR) ? ie_reg  :
                                 8'hff;

  assign int_ack        = int_ack_reg;
  assign cpu_int_req    = cpu_int_req_reg;
  assign cpu_int_vector = vec_of(idx_reg);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: a spec-level model checked every
// cycle, plus literal expectations along the directed scenarios.
module tb_interrupt_ctrl;

`ifdef INTC_VECTOR_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  localparam logic [15:0] IF_A = 16'hff0f;
  localparam logic [15:0] IE_A = 16'hffff;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic [4:0]  int_req;
  logic [4:0]  int_ack;
  logic        cpu_int_req;
  logic [7:0]  cpu_int_vector;
  logic        cpu_int_ack;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  interrupt_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .din            (din),
    .dout           (dout),
    .rd             (rd),
    .wr             (wr),
    .int_req        (int_req),
    .int_ack        (int_ack),
    .cpu_int_req    (cpu_int_req),
    .cpu_int_vector (cpu_int_vector),
    .cpu_int_ack    (cpu_int_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Priority: lowest index among set bits, -1 if none.
  function automatic int first_set(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // m_phase: 0 = nothing offered, 1 = offering to CPU, 2 = ack cycle
  logic [4:0] m_if, m_reqd, m_ack;
  logic [7:0] m_ie;
  int         m_phase, m_k;
  logic [4:0] mp, mrise, mnif, mack_n, mclr;
  int         mk, mph_n;

  always @(posedge clk) begin
    if (rst) begin
      m_if = '0; m_ie = 8'h00; m_reqd = '0; m_ack = '0; m_phase = 0; m_k = 0;
    end else begin
      mp    = m_if & m_ie[4:0];
      mrise = int_req & ~m_reqd;
      mclr  = '0;
      mack_n = '0;
      mph_n = m_phase;
      if (m_phase == 0) begin
        if (mp != 0) mph_n = 1;
      end else if (m_phase == 1) begin
        mk = LATCH ? m_k : first_set(mp);
        if (mk < 0 || !mp[mk]) mph_n = 0;
        else if (cpu_int_ack) begin
          mclr[mk] = 1'b1; mack_n[mk] = 1'b1; mph_n = 2;
        end
      end else begin
        mph_n = 0;
      end
      for (int i = 0; i < 5; i++) begin
        if (mrise[i]) mnif[i] = 1'b1;
        else if (mclr[i]) mnif[i] = 1'b0;
        else if (wr && a == IF_A) mnif[i] = din[i];
        else mnif[i] = m_if[i];
        if (wr && a == IF_A && m_if[i] && !mnif[i] && int_req[i]) mack_n[i] = 1'b1;
      end
      if (wr && a == IE_A) m_ie = din;
      if (m_phase == 0 && mph_n == 1) m_k = first_set(mnif & m_ie[4:0]);
      m_if = mnif; m_reqd = int_req; m_ack = mack_n; m_phase = mph_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  int         ck;
  logic [7:0] exp_dout;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cpu_int_req", cpu_int_req, (m_phase == 1));
      chk("m_int_ack", int_ack, m_ack);
      exp_dout = (a == IF_A) ? {3'b111, m_if} : (a == IE_A) ? m_ie : 8'hff;
      chk("m_dout", dout, exp_dout);
      if (m_phase == 1) begin
        ck = LATCH ? m_k : first_set(m_if & m_ie[4:0]);
        if (ck >= 0) chk("m_vector", cpu_int_vector, 8'h40 + 8 * ck);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [7:0] exp);
    a = addr;
    #1;
    chk(nm, dout, exp);
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    a = addr; din = data; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic dispatch();
    cpu_int_ack = 1'b1;
    cyc();
    cpu_int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = IF_A; din = 8'h00; rd = 1'b0; wr = 1'b0;
    int_req = '0; cpu_int_ack = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_req", cpu_int_req, 1'b0);
    chk("rst_ack", int_ack, 5'b0);
    chk("rst_vec", cpu_int_vector, 8'h40);
    rd_chk("rst_if", IF_A, 8'he0);
    rd_chk("rst_ie", IE_A, 8'h00);
    rd_chk("rst_other", 16'h1234, 8'hff);
    cyc();

    // 1: single source, full handshake
    wr_reg(IE_A, 8'h1f);
    int_req = 5'b01000; cyc();
    rd_chk("t1_if", IF_A, 8'he8);
    chk("t1_req_early", cpu_int_req, 1'b0);
    cyc();
    chk("t1_req", cpu_int_req, 1'b1);
    chk("t1_vec", cpu_int_vector, 8'h58);
    dispatch();
    chk("t1_ack", int_ack, 5'b01000);
    chk("t1_req_low", cpu_int_req, 1'b0);
    rd_chk("t1_if_clr", IF_A, 8'he0);
    int_req = '0; cyc();
    chk("t1_ack_once", int_ack, 5'b0);

    // 2: simultaneous sources, priority then re-offer
    int_req = 5'b10100; cyc();
    rd_chk("t2_if", IF_A, 8'hf4);
    cyc();
    chk("t2_vec", cpu_int_vector, 8'h50);
    dispatch();
    chk("t2_ack", int_ack, 5'b00100);
    rd_chk("t2_if_rem", IF_A, 8'hf0);
    int_req = 5'b10000; cyc();
    chk("t2_gap", cpu_int_req, 1'b0);
    cyc();
    chk("t2_req2", cpu_int_req, 1'b1);
    chk("t2_vec2", cpu_int_vector, 8'h60);
    dispatch();
    chk("t2_ack2", int_ack, 5'b10000);
    int_req = '0; cyc();

    // 3: disabled source stays latent; stray cpu_int_ack ignored
    wr_reg(IE_A, 8'h00);
    int_req = 5'b00001; cyc();
    rd_chk("t3_if", IF_A, 8'he1);
    dispatch();
    chk("t3_stray_ack", int_ack, 5'b0);
    chk("t3_req_off", cpu_int_req, 1'b0);
    rd_chk("t3_if_kept", IF_A, 8'he1);
    wr_reg(IE_A, 8'h01);
    chk("t3_req_w1", cpu_int_req, 1'b0);
    cyc();
    chk("t3_req_w2", cpu_int_req, 1'b1);
    chk("t3_vec", cpu_int_vector, 8'h40);
    dispatch();
    chk("t3_ack", int_ack, 5'b00001);
    int_req = '0;
    wr_reg(IE_A, 8'h1f);

    // 4: higher-priority arrival while offering
    int_req = 5'b01000; cyc(); cyc();
    chk("t4_vec_a", cpu_int_vector, 8'h58);
    int_req = 5'b01001; cyc(); cyc();
    chk("t4_vec_b", cpu_int_vector, LATCH ? 8'h58 : 8'h40);
    chk("t4_req", cpu_int_req, 1'b1);
    dispatch();
    chk("t4_ack_a", int_ack, LATCH ? 5'b01000 : 5'b00001);
    int_req = LATCH ? 5'b00001 : 5'b01000; cyc(); cyc();
    chk("t4_req2", cpu_int_req, 1'b1);
    chk("t4_vec_c", cpu_int_vector, LATCH ? 8'h40 : 8'h58);
    dispatch();
    chk("t4_ack_b", int_ack, LATCH ? 5'b00001 : 5'b01000);
    int_req = '0; cyc();

    // 5: software clear of a held request
    int_req = 5'b01000; cyc(); cyc();
    chk("t5_req", cpu_int_req, 1'b1);
    wr_reg(IF_A, 8'h00);
    chk("t5_swack", int_ack, 5'b01000);
    rd_chk("t5_if", IF_A, 8'he0);
    int_req = '0; cyc();
    chk("t5_req_drop", cpu_int_req, 1'b0);
    int_req = 5'b01000; cyc(); cyc();
    int_req = 5'b01010;
    wr_reg(IF_A, 8'h00);
    rd_chk("t5_if_edge", IF_A, 8'he2);
    chk("t5_swack2", int_ack, 5'b01000);
    int_req = 5'b00010; cyc(); cyc();
    chk("t5_req1", cpu_int_req, 1'b1);
    chk("t5_vec1", cpu_int_vector, 8'h48);
    dispatch();
    chk("t5_ack1", int_ack, 5'b00010);
    int_req = '0; cyc();

    // 6: reset while offering
    int_req = 5'b01000; cyc(); cyc();
    chk("t6_req", cpu_int_req, 1'b1);
    rst = 1'b1; cyc();
    chk("t6_req_rst", cpu_int_req, 1'b0);
    chk("t6_ack_rst", int_ack, 5'b0);
    chk("t6_vec_rst", cpu_int_vector, 8'h40);
    rd_chk("t6_if", IF_A, 8'he0);
    rd_chk("t6_ie", IE_A, 8'h00);
    int_req = '0; rst = 1'b0;
    cyc(); cyc();
    chk("t6_idle", cpu_int_req, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
